// File: rtl/in256_out1536_pack.sv
// Packs IN_W-bit beats into RATIO-beat words; tlast closes a word early (partial word).
// Latency: 1 cycle from the closing beat to m_axis_tvalid; 1 beat/cycle sustained.
// Backpressure: only a closing beat stalls, and only while the output stage is full and not draining.
module in256_out1536_pack #(
    parameter int IN_W  = 256,
    parameter int RATIO = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_W-1:0]       s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [IN_W*RATIO-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [2:0]            m_axis_tbeats,
    input  logic                  m_axis_tready
);

    localparam int OUT_W = IN_W * RATIO;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(RATIO - 1);

    // Assembly stage: beats of the word being built, plus the next free slot
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] asm_q, asm_d;

    // Output stage: the finished word presented downstream
    logic [OUT_W-1:0] out_q, out_d;
    logic             vld_q, vld_d;
    logic             last_q, last_d;
    logic [2:0]       beats_q, beats_d;

    logic             accept;
    logic             closing;
    logic [OUT_W-1:0] word;

    // Non-closing beats never touch the output stage, so they are always accepted;
    // a closing beat needs the output register free or draining this cycle.
    always_comb begin
        if ((cnt_q < LAST_SLOT) && !s_axis_tlast) begin
            s_axis_tready = 1'b1;
        end else begin
            s_axis_tready = !vld_q || m_axis_tready;
        end
    end

    assign accept  = s_axis_tvalid && s_axis_tready;
    assign closing = accept && ((cnt_q == LAST_SLOT) || s_axis_tlast);

    // Word to load on a closing beat: earlier beats, current beat at slot cnt, zeros above
    always_comb begin
        word = '0;
        for (int j = 0; j < RATIO; j++) begin
            if (j < int'(cnt_q)) begin
                word[IN_W*j +: IN_W] = asm_q[IN_W*j +: IN_W];
            end else if (j == int'(cnt_q)) begin
                word[IN_W*j +: IN_W] = s_axis_tdata;
            end
        end
    end

    // Next-state: drain on handshake first, so a same-cycle closing beat re-arms valid (zero bubble)
    always_comb begin
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        out_d   = out_q;
        vld_d   = vld_q;
        last_d  = last_q;
        beats_d = beats_q;

        if (vld_q && m_axis_tready) begin
            vld_d = 1'b0;
        end

        if (closing) begin
            out_d   = word;
            vld_d   = 1'b1;
            last_d  = s_axis_tlast;
            beats_d = 3'(cnt_q) + 3'd1;
            cnt_d   = '0;
            asm_d   = '0;
        end else if (accept) begin
            asm_d[IN_W*int'(cnt_q) +: IN_W] = s_axis_tdata;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset discards any partial word and the pending output word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            asm_q   <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            beats_q <= 3'd0;
        end else begin
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            beats_q <= beats_d;
        end
    end

    assign m_axis_tdata  = out_q;
    assign m_axis_tvalid = vld_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tbeats = beats_q;

endmodule

// File: tb/tb_in256_out1536_pack.sv
// Directed bench for in256_out1536_pack: reset, streaming, partial word, zero bubble,
// backpressure and mid-word reset; inputs change 1 time unit after the rising edge,
// outputs are sampled 1 unit after the edge and words are logged on the falling edge.
module tb_in256_out1536_pack;

    logic          clk;
    logic          rst;
    logic [255:0]  s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic [1535:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic [2:0]    m_tbeats;
    logic          m_tready;

    int tests;
    int fails;

    typedef struct {
        logic [1535:0] d;
        logic          l;
        logic [2:0]    b;
    } word_t;

    word_t q[$];

    in256_out1536_pack #(.IN_W(256), .RATIO(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tbeats (m_tbeats),
        .m_axis_tready (m_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every word that will handshake on the coming rising edge
    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) begin
            q.push_back(word_t'{d: m_tdata, l: m_tlast, b: m_tbeats});
        end
    end

    // Word with slots 0..n-1 = base+k, higher slots zero
    function automatic logic [1535:0] mk(input int base, input int n);
        logic [1535:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w[256*k +: 256] = 256'(base + k);
        return w;
    endfunction

    function automatic logic [255:0] slot(input logic [1535:0] w, input int k);
        return w[256*k +: 256];
    endfunction

    // Present one beat and hold it until accepted; returns stall cycles
    task automatic send_beat(input logic [255:0] d, input logic last, output int stalls);
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        stalls   = 0;
        #1;
        while (!s_tready && stalls < 50) begin
            @(posedge clk); #1;
            stalls++;
        end
        if (stalls >= 50) begin
            tests++; fails++;
            $display("FAIL send_beat_timeout data=%0h stalls=%0d required accept", d, stalls);
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid got %b exp 0", m_tvalid); end
        tests++; if (m_tlast !== 1'b0) begin fails++; $display("FAIL rst_tlast got %b exp 0", m_tlast); end
        tests++; if (m_tbeats !== 3'd0) begin fails++; $display("FAIL rst_tbeats got %0d exp 0", m_tbeats); end
        tests++; if (m_tdata !== 1536'd0) begin fails++; $display("FAIL rst_tdata got slot0 %0h exp 0", slot(m_tdata, 0)); end
        rst = 1'b0;
        #1;
        tests++; if (s_tready !== 1'b1) begin fails++; $display("FAIL rst_tready got %b exp 1", s_tready); end
        @(posedge clk); #1;
    endtask

    task automatic test_streaming();
        int st, tot;
        logic [1535:0] e0, e1;
        e0 = mk(0, 6); e1 = mk(6, 6);
        m_tready = 1'b1; q.delete(); tot = 0;
        for (int i = 0; i < 12; i++) begin
            send_beat(256'(i), (i == 11), st);
            tot += st;
            if (i == 5) begin
                tests++; if (m_tvalid !== 1'b1) begin fails++; $display("FAIL stream_latency tvalid got %b exp 1", m_tvalid); end
            end
        end
        repeat (3) @(posedge clk); #1;
        tests++; if (tot !== 0) begin fails++; $display("FAIL stream_stalls got %0d exp 0", tot); end
        tests++; if (q.size() !== 2) begin fails++; $display("FAIL stream_count got %0d exp 2", q.size()); end
        if (q.size() == 2) begin
            for (int k = 0; k < 6; k++) begin
                tests++; if (slot(q[0].d, k) !== slot(e0, k)) begin fails++; $display("FAIL stream_w0_slot%0d got %0h exp %0h", k, slot(q[0].d, k), slot(e0, k)); end
                tests++; if (slot(q[1].d, k) !== slot(e1, k)) begin fails++; $display("FAIL stream_w1_slot%0d got %0h exp %0h", k, slot(q[1].d, k), slot(e1, k)); end
            end
            tests++; if (q[0].b !== 3'd6) begin fails++; $display("FAIL stream_w0_beats got %0d exp 6", q[0].b); end
            tests++; if (q[1].b !== 3'd6) begin fails++; $display("FAIL stream_w1_beats got %0d exp 6", q[1].b); end
            tests++; if (q[0].l !== 1'b0) begin fails++; $display("FAIL stream_w0_last got %b exp 0", q[0].l); end
            tests++; if (q[1].l !== 1'b1) begin fails++; $display("FAIL stream_w1_last got %b exp 1", q[1].l); end
        end
    endtask

    task automatic test_partial();
        int st;
        logic [255:0] a, b;
        a = {8{32'hA5A5_0001}};
        b = {8{32'h5A5A_0002}};
        m_tready = 1'b1;
        send_beat(a, 1'b0, st);
        send_beat(b, 1'b1, st);
        tests++; if (m_tvalid !== 1'b1) begin fails++; $display("FAIL partial_tvalid got %b exp 1", m_tvalid); end
        tests++; if (m_tbeats !== 3'd2) begin fails++; $display("FAIL partial_tbeats got %0d exp 2", m_tbeats); end
        tests++; if (m_tlast !== 1'b1) begin fails++; $display("FAIL partial_tlast got %b exp 1", m_tlast); end
        tests++; if (slot(m_tdata, 0) !== a) begin fails++; $display("FAIL partial_slot0 got %0h exp %0h", slot(m_tdata, 0), a); end
        tests++; if (slot(m_tdata, 1) !== b) begin fails++; $display("FAIL partial_slot1 got %0h exp %0h", slot(m_tdata, 1), b); end
        for (int k = 2; k < 6; k++) begin
            tests++; if (slot(m_tdata, k) !== 256'd0) begin fails++; $display("FAIL partial_slot%0d got %0h exp 0", k, slot(m_tdata, k)); end
        end
        @(posedge clk); #1;
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL partial_drain tvalid got %b exp 0", m_tvalid); end
    endtask

    task automatic test_zero_bubble();
        int st;
        m_tready = 1'b1; q.delete();
        send_beat(256'hC0, 1'b1, st);
        tests++; if (slot(m_tdata, 0) !== 256'hC0) begin fails++; $display("FAIL zb_w0_slot0 got %0h exp c0", slot(m_tdata, 0)); end
        send_beat(256'hD0, 1'b1, st);
        tests++; if (st !== 0) begin fails++; $display("FAIL zb_stall got %0d exp 0", st); end
        tests++; if (m_tvalid !== 1'b1) begin fails++; $display("FAIL zb_tvalid_held got %b exp 1", m_tvalid); end
        tests++; if (slot(m_tdata, 0) !== 256'hD0) begin fails++; $display("FAIL zb_w1_slot0 got %0h exp d0", slot(m_tdata, 0)); end
        tests++; if (m_tbeats !== 3'd1) begin fails++; $display("FAIL zb_w1_beats got %0d exp 1", m_tbeats); end
        @(posedge clk); #1;
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL zb_drain tvalid got %b exp 0", m_tvalid); end
        tests++; if (q.size() !== 2) begin fails++; $display("FAIL zb_count got %0d exp 2", q.size()); end
        if (q.size() == 2) begin
            tests++; if (slot(q[0].d, 0) !== 256'hC0) begin fails++; $display("FAIL zb_order0 got %0h exp c0", slot(q[0].d, 0)); end
            tests++; if (slot(q[1].d, 0) !== 256'hD0) begin fails++; $display("FAIL zb_order1 got %0h exp d0", slot(q[1].d, 0)); end
        end
    endtask

    task automatic test_backpressure();
        int st, tot;
        logic [1535:0] e0, e1;
        e0 = mk(100, 6); e1 = mk(106, 6);
        m_tready = 1'b0; q.delete(); tot = 0;
        for (int i = 0; i < 11; i++) begin
            send_beat(256'(100 + i), 1'b0, st);
            tot += st;
        end
        tests++; if (tot !== 0) begin fails++; $display("FAIL bp_accept_stalls got %0d exp 0", tot); end
        // Beat 11 closes word 1 while word 0 is still held
        s_tdata = 256'd111; s_tlast = 1'b1; s_tvalid = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL bp_stall_tready cyc%0d got %b exp 0", c, s_tready); end
            tests++; if (m_tvalid !== 1'b1) begin fails++; $display("FAIL bp_hold_tvalid cyc%0d got %b exp 1", c, m_tvalid); end
            tests++; if (m_tdata !== e0) begin fails++; $display("FAIL bp_hold_data cyc%0d slot0 got %0h exp %0h", c, slot(m_tdata, 0), slot(e0, 0)); end
            @(posedge clk); #1;
        end
        m_tready = 1'b1;
        #1;
        tests++; if (s_tready !== 1'b1) begin fails++; $display("FAIL bp_release_tready got %b exp 1", s_tready); end
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0;
        tests++; if (m_tvalid !== 1'b1) begin fails++; $display("FAIL bp_w1_tvalid got %b exp 1", m_tvalid); end
        tests++; if (m_tdata !== e1) begin fails++; $display("FAIL bp_w1_data slot5 got %0h exp %0h", slot(m_tdata, 5), slot(e1, 5)); end
        tests++; if (m_tlast !== 1'b1) begin fails++; $display("FAIL bp_w1_last got %b exp 1", m_tlast); end
        @(posedge clk); #1;
        tests++; if (q.size() !== 2) begin fails++; $display("FAIL bp_count got %0d exp 2", q.size()); end
        if (q.size() == 2) begin
            tests++; if (q[0].d !== e0) begin fails++; $display("FAIL bp_order0 slot0 got %0h exp %0h", slot(q[0].d, 0), slot(e0, 0)); end
            tests++; if (q[1].d !== e1) begin fails++; $display("FAIL bp_order1 slot0 got %0h exp %0h", slot(q[1].d, 0), slot(e1, 0)); end
            tests++; if (q[0].l !== 1'b0) begin fails++; $display("FAIL bp_w0_last got %b exp 0", q[0].l); end
        end
    endtask

    task automatic test_mid_reset();
        int st;
        logic [1535:0] e;
        e = mk(20, 6);
        m_tready = 1'b0;
        for (int i = 0; i < 9; i++) send_beat(256'(50 + i), 1'b0, st);
        tests++; if (m_tvalid !== 1'b1) begin fails++; $display("FAIL mr_pre_tvalid got %b exp 1", m_tvalid); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL mr_async_tvalid got %b exp 0", m_tvalid); end
        tests++; if (m_tbeats !== 3'd0) begin fails++; $display("FAIL mr_async_tbeats got %0d exp 0", m_tbeats); end
        tests++; if (m_tdata !== 1536'd0) begin fails++; $display("FAIL mr_async_tdata slot0 got %0h exp 0", slot(m_tdata, 0)); end
        @(posedge clk); #1;
        rst = 1'b0; m_tready = 1'b1; q.delete();
        for (int i = 0; i < 6; i++) send_beat(256'(20 + i), 1'b0, st);
        repeat (3) @(posedge clk); #1;
        tests++; if (q.size() !== 1) begin fails++; $display("FAIL mr_count got %0d exp 1", q.size()); end
        if (q.size() == 1) begin
            for (int k = 0; k < 6; k++) begin
                tests++; if (slot(q[0].d, k) !== slot(e, k)) begin fails++; $display("FAIL mr_slot%0d got %0h exp %0h", k, slot(q[0].d, k), slot(e, k)); end
            end
            tests++; if (q[0].b !== 3'd6) begin fails++; $display("FAIL mr_beats got %0d exp 6", q[0].b); end
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        test_reset();
        test_streaming();
        test_partial();
        test_zero_bubble();
        test_backpressure();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
